ampel_phase_sequencer: RTL and testbench
========================================

Name: ampel_phase_sequencer

Overview:
- Synchronous controller that sequences the pedestrian-crossing traffic light.
- Replaces the ad-hoc request flip-flop and free-running counter with one FSM that:
  - latches pedestrian requests;
  - enforces a minimum car-green time;
  - times every phase from a slow tick.
- Drives the phase index ZUST and the lamp vectors KFZA and FA.
- Sits between the clock generator (supplies TICK) and the lamp decoder / LED outputs.

Parameters:
- T_GRUEN_MIN, 10, minimum car-green duration in ticks (≥1)
- T_GELB, 3, car-yellow duration in ticks (≥1)
- T_ROT_SICHER, 2, all-red clearance duration in ticks (≥1)
- T_FG, 8, pedestrian-green duration in ticks (≥1)
- T_ROTGELB, 1, car red+yellow duration in ticks (≥1)
- TW, 5, timer width; every T_* must be ≤ 2^TW

Ports:
- CLK  in  1  system clock
- RES  in  1  reset, synchronous, active-low
- TICK  in  1  one-CLK-wide phase-time enable from the clock generator
- ANF  in  1  pedestrian request button, asynchronous, debounced
- ZUST  out  4  current phase index, 0..5
- KFZA  out  3  car lamps {rot, gelb, gruen}
- FA  out  2  pedestrian lamps {rot, gruen}
- ANF_ACK  out  1  "Signal kommt" lamp; high while a request is pending

Behaviour:
- Reset (RES=0 at a CLK edge, any state, mid-phase included):
  - phase KFZ_GRUEN; ZUST=0; KFZA=001; FA=10; ANF_ACK=0.
  - Synchronizer flops cleared.
  - Phase timer loaded with T_GRUEN_MIN-1.
- ANF path:
  - two-flop synchronizer, then rising-edge detect.
  - An edge reaches the pending latch 3 CLK after the ANF rise.
- Pending latch:
  - set by an edge in any phase except FG_GRUEN.
  - cleared on the CLK edge that enters FG_GRUEN; clear wins over a simultaneous set.
  - edges during FG_GRUEN are ignored.
  - ANF_ACK = latch output, registered.
- Phases (ZUST, KFZA, FA), timer reload value on entry, and exit condition:
  - 0 KFZ_GRUEN: 001, 10; reload T_GRUEN_MIN-1; exits to 1 when timer==0 and pending=1.
  - 1 KFZ_GELB: 010, 10; reload T_GELB-1; exits to 2 on expiry.
  - 2 ROT_SICHER1: 100, 10; reload T_ROT_SICHER-1; exits to 3 on expiry.
  - 3 FG_GRUEN: 100, 01; reload T_FG-1; exits to 4 on expiry.
  - 4 ROT_SICHER2: 100, 10; reload T_ROT_SICHER-1; exits to 5 on expiry.
  - 5 KFZ_ROTGELB: 110, 10; reload T_ROTGELB-1; exits to 0 on expiry.
- Expiry: TICK=1 while timer==0.
- Timer decrement: on TICK when timer≠0. In phase 0 the timer saturates at 0 while no request is pending.
- Phase length: every phase except 0 lasts exactly T_x TICKs after the entering TICK. Phase 0 lasts max(T_GRUEN_MIN, time to request) TICKs.
- Phase-0 exit timing: a request arriving after min-green has elapsed is served at the next TICK.
- Transitions occur only on TICK cycles. TICK held high for consecutive CLKs counts each cycle; this is legal.
- Outputs: registered, change on the transition edge. KFZA and FA never show car green/yellow together with pedestrian green.
- Unreachable ZUST codes 6..15 recover to KFZ_GRUEN on the next CLK.

Decomposition:
- ampel_pkg contains:
  - phase enum (KFZ_GRUEN..KFZ_ROTGELB, 4-bit);
  - lamp constants L_KFZ_GRUEN=001, L_KFZ_GELB=010, L_KFZ_ROT=100, L_KFZ_ROTGELB=110, L_FG_ROT=10, L_FG_GRUEN=01;
  - default T_* values.
- One sub-module: phase_timer (TW-bit loadable down-counter with tick enable and zero flag). Everything else is inline.

Test Plan:
- Reset, then 50 TICKs with ANF=0 → ZUST stays 0, KFZA=001, FA=10, ANF_ACK=0.
- ANF pulse at TICK 2 after reset → ANF_ACK=1 after 3 CLK. Phase 1 entered at TICK 10, then phase sequence 1,2,3,4,5,0 held for 3,2,8,2,1 TICKs. FA=01 only in phase 3. ANF_ACK drops on entry to phase 3.
- ANF pulse at TICK 20 (min-green elapsed) → phase 1 entered on the first TICK after the latch sets.
- ANF pulses during phase 3 → ignored; return to phase 0 with ANF_ACK=0. ANF pulse during phase 1 → ANF_ACK=1 persists, and a second cycle starts 10 TICKs after re-entering phase 0.
- RES=0 for one CLK while in phase 3 → next cycle ZUST=0, KFZA=001, FA=10, ANF_ACK=0. The min-green timer restarts at 10 TICKs.
- TICK held high continuously with a pending request → each phase lasts T_x CLKs; sequence order unchanged.

Source files
------------

// File: rtl/ampel_pkg.sv
// ampel_pkg: shared types and constants for the pedestrian-crossing sequencer.
//   phase_e     : phase index as driven on ZUST (0..5)
//   L_*         : lamp patterns, car {rot,gelb,gruen}, pedestrian {rot,gruen}
//   T_*_DEF     : default phase durations in ticks
//   kfz_lamps / fg_lamps : phase -> lamp vector decode
package ampel_pkg;

  typedef enum logic [3:0] {
    KFZ_GRUEN   = 4'd0,
    KFZ_GELB    = 4'd1,
    ROT_SICHER1 = 4'd2,
    FG_GRUEN    = 4'd3,
    ROT_SICHER2 = 4'd4,
    KFZ_ROTGELB = 4'd5
  } phase_e;

  localparam logic [2:0] L_KFZ_GRUEN   = 3'b001;
  localparam logic [2:0] L_KFZ_GELB    = 3'b010;
  localparam logic [2:0] L_KFZ_ROT     = 3'b100;
  localparam logic [2:0] L_KFZ_ROTGELB = 3'b110;
  localparam logic [1:0] L_FG_ROT      = 2'b10;
  localparam logic [1:0] L_FG_GRUEN    = 2'b01;

  localparam int T_GRUEN_MIN_DEF  = 10;
  localparam int T_GELB_DEF       = 3;
  localparam int T_ROT_SICHER_DEF = 2;
  localparam int T_FG_DEF         = 8;
  localparam int T_ROTGELB_DEF    = 1;
  localparam int TW_DEF           = 5;

  // Anything not a car-moving phase shows car red, so an illegal phase code
  // can never light car green/yellow.
  function automatic logic [2:0] kfz_lamps(input phase_e p);
    case (p)
      KFZ_GRUEN:   kfz_lamps = L_KFZ_GRUEN;
      KFZ_GELB:    kfz_lamps = L_KFZ_GELB;
      KFZ_ROTGELB: kfz_lamps = L_KFZ_ROTGELB;
      default:     kfz_lamps = L_KFZ_ROT;
    endcase
  endfunction

  function automatic logic [1:0] fg_lamps(input phase_e p);
    fg_lamps = (p == FG_GRUEN) ? L_FG_GRUEN : L_FG_ROT;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: TW-bit loadable down-counter for phase timing.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset, loads RST_VAL
//   tick_i     : decrement enable (one step per tick, stops at zero)
//   load_i     : load load_val_i (has priority over the decrement)
//   load_val_i : reload value for the phase being entered
//   zero_o     : counter is zero
module phase_timer #(
  parameter int             TW      = 5,
  parameter logic [TW-1:0]  RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Holding at zero is what lets car-green wait indefinitely for a request.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ampel_phase_sequencer.sv
// ampel_phase_sequencer: pedestrian-crossing traffic light controller.
//   CLK     : system clock
//   RES     : synchronous active-low reset
//   TICK    : one-CLK phase-time enable; every high cycle counts
//   ANF     : pedestrian request button (asynchronous, debounced)
//   ZUST    : current phase index 0..5
//   KFZA    : car lamps {rot, gelb, gruen}
//   FA      : pedestrian lamps {rot, gruen}
//   ANF_ACK : "Signal kommt", high while a request is pending
module ampel_phase_sequencer
  import ampel_pkg::*;
#(
  parameter int T_GRUEN_MIN  = T_GRUEN_MIN_DEF,
  parameter int T_GELB       = T_GELB_DEF,
  parameter int T_ROT_SICHER = T_ROT_SICHER_DEF,
  parameter int T_FG         = T_FG_DEF,
  parameter int T_ROTGELB    = T_ROTGELB_DEF,
  parameter int TW           = TW_DEF
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       TICK,
  input  logic       ANF,
  output logic [3:0] ZUST,
  output logic [2:0] KFZA,
  output logic [1:0] FA,
  output logic       ANF_ACK
);

  // Reload values are duration-1: the entering tick is not counted.
  localparam logic [TW-1:0] R_GRUEN   = TW'(T_GRUEN_MIN - 1);
  localparam logic [TW-1:0] R_GELB    = TW'(T_GELB - 1);
  localparam logic [TW-1:0] R_ROT     = TW'(T_ROT_SICHER - 1);
  localparam logic [TW-1:0] R_FG      = TW'(T_FG - 1);
  localparam logic [TW-1:0] R_ROTGELB = TW'(T_ROTGELB - 1);

  phase_e        state_q, state_d;
  logic [2:0]    sync_q;   // [0],[1] synchronizer, [2] previous sample for edge detect
  logic          pend_q, pend_d;
  logic [2:0]    kfza_q;
  logic [1:0]    fa_q;
  logic          tmr_zero, tmr_load;
  logic [TW-1:0] tmr_val;
  logic          expire, anf_rise, enter_fg;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (R_GRUEN)
  ) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RES),
    .tick_i     (TICK),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign expire   = TICK && tmr_zero;
  assign anf_rise = sync_q[1] && !sync_q[2];

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = R_GRUEN;
    case (state_q)
      KFZ_GRUEN: begin
        if (expire && pend_q) begin
          state_d  = KFZ_GELB;
          tmr_load = 1'b1;
          tmr_val  = R_GELB;
        end
      end
      KFZ_GELB: begin
        if (expire) begin
          state_d  = ROT_SICHER1;
          tmr_load = 1'b1;
          tmr_val  = R_ROT;
        end
      end
      ROT_SICHER1: begin
        if (expire) begin
          state_d  = FG_GRUEN;
          tmr_load = 1'b1;
          tmr_val  = R_FG;
        end
      end
      FG_GRUEN: begin
        if (expire) begin
          state_d  = ROT_SICHER2;
          tmr_load = 1'b1;
          tmr_val  = R_ROT;
        end
      end
      ROT_SICHER2: begin
        if (expire) begin
          state_d  = KFZ_ROTGELB;
          tmr_load = 1'b1;
          tmr_val  = R_ROTGELB;
        end
      end
      KFZ_ROTGELB: begin
        if (expire) begin
          state_d  = KFZ_GRUEN;
          tmr_load = 1'b1;
          tmr_val  = R_GRUEN;
        end
      end
      default: begin
        state_d  = KFZ_GRUEN;
        tmr_load = 1'b1;
        tmr_val  = R_GRUEN;
      end
    endcase
  end

  // The request being served is consumed on entry to pedestrian green; the
  // clear beats a same-cycle edge, and edges during pedestrian green are dropped.
  assign enter_fg = (state_d == FG_GRUEN) && (state_q != FG_GRUEN);

  always_comb begin
    pend_d = pend_q;
    if (enter_fg) begin
      pend_d = 1'b0;
    end else if (anf_rise && (state_q != FG_GRUEN)) begin
      pend_d = 1'b1;
    end
  end

  // Lamps are decoded from the next phase so they switch on the transition edge.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q <= KFZ_GRUEN;
      sync_q  <= '0;
      pend_q  <= 1'b0;
      kfza_q  <= L_KFZ_GRUEN;
      fa_q    <= L_FG_ROT;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], ANF};
      pend_q  <= pend_d;
      kfza_q  <= kfz_lamps(state_d);
      fa_q    <= fg_lamps(state_d);
    end
  end

  assign ZUST    = state_q;
  assign KFZA    = kfza_q;
  assign FA      = fa_q;
  assign ANF_ACK = pend_q;

endmodule

// File: tb/tb_ampel_phase_sequencer.sv
module tb_ampel_phase_sequencer;

  logic       CLK, RES, TICK, ANF;
  logic [3:0] ZUST;
  logic [2:0] KFZA;
  logic [1:0] FA;
  logic       ANF_ACK;

  ampel_phase_sequencer dut (
    .CLK     (CLK),
    .RES     (RES),
    .TICK    (TICK),
    .ANF     (ANF),
    .ZUST    (ZUST),
    .KFZA    (KFZA),
    .FA      (FA),
    .ANF_ACK (ANF_ACK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference: phase durations in ticks and the car lamps shown in each phase.
  int         dur[6]     = '{10, 3, 2, 8, 2, 1};
  logic [2:0] kfza_of[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b110};

  // Model state: phase, ticks counted since entry, pending flag, and the last
  // three ANF values sampled at clock edges.
  int   m_p, m_c;
  logic m_pend, h1, h2, h3;

  typedef struct {
    logic       res;
    logic       tick;
    logic       anf;
    int         rep;
    logic [3:0] zust;
    logic [2:0] kfza;
    logic [1:0] fa;
    logic       ack;
  } vec_t;

  vec_t vt[17];

  int   n_t;
  int   len[6];
  int   order[$];
  int   prev;
  logic anf_lvl;
  int   exp_order[6] = '{1, 2, 3, 4, 5, 0};

  task automatic model_step(input logic t, input logic a, input logic r);
    logic evt;
    int   old_p;
    logic enter3;
    if (!r) begin
      m_p = 0; m_c = 0; m_pend = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      // A request is seen two edges after it is first sampled high.
      evt = h2 && !h3;
      h3 = h2; h2 = h1; h1 = a;
      old_p  = m_p;
      enter3 = 1'b0;
      if (t) begin
        if ((m_c + 1 >= dur[m_p]) && (m_p != 0 || m_pend)) begin
          m_p    = (m_p + 1) % 6;
          m_c    = 0;
          enter3 = (m_p == 3);
        end else if (m_c < 1000) begin
          m_c = m_c + 1;
        end
      end
      if (enter3) m_pend = 1'b0;
      else if (evt && old_p != 3) m_pend = 1'b1;
    end
  endtask

  task automatic check(input string nm, input logic [3:0] z, input logic [2:0] k,
                       input logic [1:0] f, input logic a);
    n_vec++;
    if (ZUST !== z || KFZA !== k || FA !== f || ANF_ACK !== a) begin
      n_bad++;
      $display("FAIL %s @%0t: got ZUST=%0d KFZA=%b FA=%b ACK=%b, want ZUST=%0d KFZA=%b FA=%b ACK=%b",
               nm, $time, ZUST, KFZA, FA, ANF_ACK, z, k, f, a);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
    end
  endtask

  // One clock: apply inputs, clock, advance model, compare shortly after the edge.
  task automatic cyc(input logic t, input logic a, input logic r);
    TICK = t; ANF = a; RES = r;
    @(posedge CLK);
    model_step(t, a, r);
    #1;
    check("model", 4'(m_p), kfza_of[m_p], (m_p == 3) ? 2'b01 : 2'b10, m_pend);
    n_vec++;
    if (FA === 2'b01 && KFZA[1:0] !== 2'b00) begin
      n_bad++;
      $display("FAIL safety @%0t: got KFZA=%b with FA=%b, want no car green/yellow", $time, KFZA, FA);
    end
  endtask

  task automatic pulse_anf();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick_until(input int target, input int budget, output int n, input string nm);
    n = 0;
    while (ZUST !== 4'(target) && n < budget) begin
      cyc(1'b1, 1'b0, 1'b1);
      n++;
    end
    if (ZUST !== 4'(target)) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got ZUST=%0d after %0d ticks, want %0d", nm, ZUST, n, target);
    end
  endtask

  initial begin
    RES = 1'b0; TICK = 1'b0; ANF = 1'b0;

    // res, tick, anf, repeat, ZUST, KFZA, FA, ACK
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1, 4'd0, 3'b001, 2'b10, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 2, 4'd0, 3'b001, 2'b10, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1, 4'd0, 3'b001, 2'b10, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1, 4'd0, 3'b001, 2'b10, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1, 4'd0, 3'b001, 2'b10, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 7, 4'd0, 3'b001, 2'b10, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1, 4'd1, 3'b010, 2'b10, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 2, 4'd1, 3'b010, 2'b10, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1, 4'd2, 3'b100, 2'b10, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1, 4'd2, 3'b100, 2'b10, 1'b1};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1, 4'd3, 3'b100, 2'b01, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 7, 4'd3, 3'b100, 2'b01, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1, 4'd4, 3'b100, 2'b10, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1, 4'd4, 3'b100, 2'b10, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1, 4'd5, 3'b110, 2'b10, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 1, 4'd0, 3'b001, 2'b10, 1'b0};
    vt[16] = '{1'b1, 1'b0, 1'b0, 3, 4'd0, 3'b001, 2'b10, 1'b0};

    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < vt[i].rep; j++) begin
        cyc(vt[i].tick, vt[i].anf, vt[i].res);
        check($sformatf("table%0d", i), vt[i].zust, vt[i].kfza, vt[i].fa, vt[i].ack);
      end
    end

    // Pulses during phases 1, 3 and 4; second cycle starts 10 ticks after phase 0.
    pulse_anf();
    check_int("ack_after_pulse", int'(ANF_ACK), 1);
    tick_until(1, 40, n_t, "reach_p1");
    check_int("mingreen_ticks_a", n_t, 10);
    pulse_anf();
    check_int("ack_pulse_in_p1", int'(ANF_ACK), 1);
    tick_until(3, 40, n_t, "reach_p3");
    check_int("ack_clear_p3", int'(ANF_ACK), 0);
    pulse_anf();
    check_int("ack_ignored_p3", int'(ANF_ACK), 0);
    tick_until(4, 40, n_t, "reach_p4");
    check_int("ack_in_p4", int'(ANF_ACK), 0);
    pulse_anf();
    check_int("ack_pulse_in_p4", int'(ANF_ACK), 1);
    tick_until(0, 40, n_t, "reach_p0");
    check_int("ack_back_in_p0", int'(ANF_ACK), 1);
    tick_until(1, 40, n_t, "reach_p1_again");
    check_int("second_cycle_ticks", n_t, 10);

    // Reset in pedestrian green, then min-green restarts at 10 ticks.
    tick_until(3, 40, n_t, "reach_p3_rst");
    cyc(1'b0, 1'b0, 1'b0);
    check("reset_in_p3", 4'd0, 3'b001, 2'b10, 1'b0);
    pulse_anf();
    tick_until(1, 40, n_t, "reach_p1_after_rst");
    check_int("mingreen_after_rst", n_t, 10);

    // No request: 50 ticks in car green.
    cyc(1'b0, 1'b0, 1'b0);
    repeat (50) cyc(1'b1, 1'b0, 1'b1);
    check("idle_50_ticks", 4'd0, 3'b001, 2'b10, 1'b0);

    // Request after min-green: served at the first tick after the latch sets.
    cyc(1'b0, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 1'b1);
    pulse_anf();
    check("late_req_latched", 4'd0, 3'b001, 2'b10, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("late_req_served", 4'd1, 3'b010, 2'b10, 1'b1);

    // TICK held high: each phase lasts its duration in clocks, in order.
    cyc(1'b0, 1'b0, 1'b0);
    pulse_anf();
    for (int p = 0; p < 6; p++) len[p] = 0;
    order.delete();
    prev = 0;
    for (int i = 0; i < 80 && order.size() < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (int'(ZUST) != prev) begin
        order.push_back(int'(ZUST));
        prev = int'(ZUST);
      end
      if (ZUST < 4'd6) len[ZUST]++;
    end
    check_int("cont_tick_phases", order.size(), 6);
    for (int p = 1; p < 6; p++) check_int($sformatf("cont_tick_len_p%0d", p), len[p], dur[p]);
    for (int i = 0; i < order.size() && i < 6; i++)
      check_int($sformatf("cont_tick_order%0d", i), order[i], exp_order[i]);

    // Random stimulus against the reference model.
    cyc(1'b0, 1'b0, 1'b0);
    anf_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) anf_lvl = ~anf_lvl;
      cyc(($urandom_range(2) == 0), anf_lvl, ($urandom_range(599) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
